input_checker: RTL and testbench
================================

# input_checker

Player-input stage directly downstream of the pattern shifter in the Simon datapath. Synchronises the four colour buttons and detects a single press. Each press is encoded to a 2-bit colour and compared against the shifter's `compare` output. On a match it pulses `next` to advance the shifter; the round ends with a one-cycle `round_pass` or `round_fail` pulse to the game controller.

## Interface
- `SEQ_LEN`, 2: colours per round; a 4-bit pattern holds 2 colours.
- `TIMEOUT`, 50_000_000: cycles allowed per press; 1 s at 50 MHz.
- `clk` in 1: single system clock; rising edge.
- `resetn` in 1: reset, asynchronous and active-low.
- `start` in 1: one-cycle pulse from the controller after the shifter has been loaded.
- `key` in 4: raw buttons, active-high, asynchronous to `clk`. Colour map: `key[0]`→00, `key[1]`→01, `key[2]`→10, `key[3]`→11.
- `compare` in 2: expected colour from the shifter. Valid one cycle after `next`.
- `next` out 1: one-cycle pulse; the shifter presents the next colour.
- `busy` out 1: high in every state except IDLE.
- `round_pass` out 1: one-cycle pulse when all `SEQ_LEN` colours have matched.
- `round_fail` out 1: one-cycle pulse on a wrong colour, a multi-key press or a timeout.
- `match_count` out `$clog2(SEQ_LEN+1)`: colours matched in the current round.
- `last_color` out 2: encoded colour of the most recent accepted press.

## Operation
- `key` passes through a 2-flop synchroniser to give `key_s`. Reset clears both flops.
- All outputs are Moore-decoded from the state register or taken directly from registers, so they are glitch-free.
- States: IDLE, PRIME, WAIT_RELEASE, WAIT_PRESS, CHECK, ADVANCE, PASS, FAIL.
- IDLE:
  - `start`=1 → PRIME and clear `match_count`.
  - `start` is ignored in every other state.
- PRIME:
  - `next`=1 for this one cycle; this primes the first colour into `compare`.
  - Always → WAIT_RELEASE.
- WAIT_RELEASE:
  - `key_s`==0 → WAIT_PRESS and clear the timeout counter.
  - Otherwise stay; no timeout applies here.
- WAIT_PRESS:
  - The timeout counter increments every cycle.
  - `key_s`≠0 → CHECK and capture `key_s` into `press_reg`.
  - Otherwise, counter == `TIMEOUT`-1 → FAIL.
  - A press and the timeout in the same cycle: the press wins.
- CHECK:
  - `press_reg` not one-hot → FAIL.
  - Else set `last_color` to the encoded colour.
  - Encoded colour ≠ `compare` → FAIL.
  - Encoded colour == `compare`: `match_count`++. If the new count == `SEQ_LEN` → PASS, else → ADVANCE.
- ADVANCE:
  - `next`=1 for one cycle.
  - Always → WAIT_RELEASE. The minimum one-cycle stay there lets `compare` update.
- PASS:
  - `round_pass`=1 for one cycle.
  - Always → IDLE.
- FAIL:
  - `round_fail`=1 for one cycle.
  - Always → IDLE. `match_count` holds its value until the next `start`.
- Exactly one of `next`, `round_pass` and `round_fail` is high in any cycle, or none.
- A held key never produces a second press. The key must release, which returns the FSM to WAIT_PRESS, before the next press is accepted.

## Timing
- Reset values: state IDLE, all outputs 0, counters 0.
- Reset asserted mid-round returns the block to IDLE at once. No pass or fail pulse is issued.
- `start` sampled at edge E: `next` is high during the cycle after E. `compare` is valid from edge E+2.
- Press latency: take E0 as the edge that first samples `key` high into the synchroniser.
  - `key_s` is high after E0+1.
  - CHECK is occupied after E0+2.
  - `next`, `round_pass` or `round_fail` is high in the cycle after E0+3.
- The timeout counter is 26 bits, or `$clog2(TIMEOUT)` bits when that is wider. It does not wrap: FAIL is taken first.
- Minimum round length is `SEQ_LEN`×(press-to-release cycles) + 3.

## Test plan
Bench parameters: `SEQ_LEN`=2, `TIMEOUT`=16. `compare` is driven by a behavioural shifter model loaded with 4'b1001, which yields colour 01 then 10.
- Correct round: `start`; press and release `key`=0010, then press `key`=0100.
  - Required: `next` pulses after `start`, and again 4 cycles after the first press.
  - Then `round_pass` pulses once, `match_count`=2 and `last_color`=10.
- Wrong colour: `start`, then press `key`=1000.
  - Required: `round_fail` pulses 4 cycles after the press, `match_count`=0, `last_color`=11, and there is no second `next`.
- Multi-key press: `start`, then `key`=0011 on the same edge.
  - Required: `round_fail` pulses and `last_color` stays 0.
- Timeout: `start`, then no key.
  - Required: `round_fail` pulses 16 cycles after WAIT_PRESS is entered, and `busy` falls the cycle after.
- Held key and mid-round reset:
  - Hold `key`=0010 for 40 cycles. Required: exactly one `next` after PRIME, and no pass, fail or timeout.
  - Assert `resetn`=0 asynchronously. Required: `busy` and all outputs read 0 immediately; after release the state is IDLE and `start` while busy was ignored.

Source files
------------

// File: rtl/input_checker.sv
// Simon player-input stage: synchronises the colour buttons, accepts one press at a
// time and checks each press against the pattern shifter's current colour.
module input_checker #(
   parameter int SEQ_LEN = 2,
   parameter int TIMEOUT = 50_000_000
) (
   input  logic                         clk,
   input  logic                         resetn,
   input  logic                         start,
   input  logic [3:0]                   key,
   input  logic [1:0]                   compare,
   output logic                         next,
   output logic                         busy,
   output logic                         round_pass,
   output logic                         round_fail,
   output logic [$clog2(SEQ_LEN+1)-1:0] match_count,
   output logic [1:0]                   last_color
);

   localparam int MW = $clog2(SEQ_LEN+1);
   localparam int CW = ($clog2(TIMEOUT) > 26) ? $clog2(TIMEOUT) : 26;

   typedef enum logic [2:0] {
      IDLE, PRIME, WAIT_RELEASE, WAIT_PRESS, CHECK, ADVANCE, PASS, FAIL
   } state_t;

   state_t        state, state_nxt;
   logic [3:0]    sync1, key_s, press_reg;
   logic [CW-1:0] tcnt;
   logic [1:0]    color;
   logic          one_hot, hit, last_hit;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         sync1 <= 4'b0;
         key_s <= 4'b0;
      end else begin
         sync1 <= key;
         key_s <= sync1;
      end
   end

   assign one_hot  = (press_reg != 4'b0) && ((press_reg & (press_reg - 4'd1)) == 4'b0);
   assign hit      = one_hot && (color == compare);
   assign last_hit = (match_count == MW'(SEQ_LEN-1));

   always_comb begin
      color = 2'b00;
      case (press_reg)
         4'b0010: color = 2'b01;
         4'b0100: color = 2'b10;
         4'b1000: color = 2'b11;
         default: color = 2'b00;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) state <= IDLE;
      else         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:         if (start) state_nxt = PRIME;
         PRIME:        state_nxt = WAIT_RELEASE;
         WAIT_RELEASE: if (key_s == 4'b0) state_nxt = WAIT_PRESS;
         // a press arriving on the last allowed cycle still counts
         WAIT_PRESS: begin
            if (key_s != 4'b0)                 state_nxt = CHECK;
            else if (tcnt == CW'(TIMEOUT - 1)) state_nxt = FAIL;
         end
         CHECK: begin
            if (!hit)          state_nxt = FAIL;
            else if (last_hit) state_nxt = PASS;
            else               state_nxt = ADVANCE;
         end
         ADVANCE:      state_nxt = WAIT_RELEASE;
         PASS:         state_nxt = IDLE;
         FAIL:         state_nxt = IDLE;
         default:      state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         tcnt        <= '0;
         press_reg   <= 4'b0;
         match_count <= '0;
         last_color  <= 2'b00;
      end else begin
         case (state)
            IDLE:         if (start) match_count <= '0;
            WAIT_RELEASE: if (key_s == 4'b0) tcnt <= '0;
            WAIT_PRESS: begin
               tcnt <= tcnt + 1'b1;
               if (key_s != 4'b0) press_reg <= key_s;
            end
            CHECK: begin
               if (one_hot) begin
                  last_color <= color;
                  if (hit) match_count <= match_count + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign next       = (state == PRIME) || (state == ADVANCE);
   assign busy       = (state != IDLE);
   assign round_pass = (state == PASS);
   assign round_fail = (state == FAIL);

endmodule

// File: tb/tb_input_checker.sv
// Bench for input_checker: behavioural pattern shifter loaded with 4'b1001 feeds
// compare; observed pulses are scoreboarded against expected events.
module tb_input_checker;
   localparam int SEQ_LEN = 2;
   localparam int TIMEOUT = 16;

   logic       clk = 1'b0;
   logic       resetn, start;
   logic [3:0] key;
   logic [1:0] compare;
   logic       next, busy, round_pass, round_fail;
   logic [1:0] match_count, last_color;

   int checks = 0, failures = 0, cyc = 0;

   input_checker #(.SEQ_LEN(SEQ_LEN), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .resetn(resetn), .start(start), .key(key), .compare(compare),
      .next(next), .busy(busy), .round_pass(round_pass), .round_fail(round_fail),
      .match_count(match_count), .last_color(last_color)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // shifter model: first colour is the low pair, presented after each next
   logic [3:0] sh;
   always @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         sh <= 4'b0; compare <= 2'b00;
      end else if (start && !busy) begin
         sh <= 4'b1001;
      end else if (next) begin
         compare <= sh[1:0];
         sh      <= {2'b00, sh[3:2]};
      end
   end

   typedef struct { int cyc; int kind; int mc; int lc; } ev_t;
   ev_t exp_q[$];
   ev_t got_q[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s: got %0d required %0d", name, act, req);
      end
   endtask

   always @(negedge clk) begin
      if (resetn === 1'b1 && (next || round_pass || round_fail)) begin
         ev_t e;
         check("pulse_exclusive", $countones({next, round_pass, round_fail}), 1);
         e.cyc = cyc;
         e.kind = next ? 0 : (round_pass ? 1 : 2);
         e.mc = match_count;
         e.lc = last_color;
         got_q.push_back(e);
      end
   end

   task automatic expect_ev(input int c, input int k, input int mc, input int lc);
      ev_t e;
      e.cyc = c; e.kind = k; e.mc = mc; e.lc = lc;
      exp_q.push_back(e);
   endtask

   task automatic check_events(input string name);
      ev_t e, g;
      check({name, "_event_count"}, got_q.size(), exp_q.size());
      while (exp_q.size() > 0 && got_q.size() > 0) begin
         e = exp_q.pop_front();
         g = got_q.pop_front();
         check({name, "_event_kind"}, g.kind, e.kind);
         check({name, "_event_cycle"}, g.cyc, e.cyc);
         check({name, "_event_match_count"}, g.mc, e.mc);
         check({name, "_event_last_color"}, g.lc, e.lc);
      end
      exp_q.delete();
      got_q.delete();
   endtask

   task automatic do_reset();
      resetn = 1'b0; start = 1'b0; key = 4'b0;
      repeat (3) @(negedge clk);
      resetn = 1'b1;
      @(negedge clk);
      exp_q.delete();
      got_q.delete();
   endtask

   task automatic pulse_start(output int c);
      c = cyc;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   typedef struct { logic [3:0] key; int kind; int mc; int lc; } vec_t;
   vec_t tbl[6];

   int c, p;

   initial begin
      tbl[0] = '{4'b0010, 0, 1, 1};  // right first colour: advance
      tbl[1] = '{4'b0001, 2, 0, 0};  // wrong colour 00
      tbl[2] = '{4'b0100, 2, 0, 2};  // wrong colour 10
      tbl[3] = '{4'b1000, 2, 0, 3};  // wrong colour 11
      tbl[4] = '{4'b0011, 2, 0, 0};  // multi-key
      tbl[5] = '{4'b1100, 2, 0, 0};  // multi-key

      do_reset();
      check("reset_busy", busy, 0);
      check("reset_next", next, 0);
      check("reset_pass", round_pass, 0);
      check("reset_fail", round_fail, 0);
      check("reset_match_count", match_count, 0);
      check("reset_last_color", last_color, 0);

      for (int i = 0; i < 6; i++) begin
         do_reset();
         pulse_start(c);
         expect_ev(c + 1, 0, 0, 0);
         repeat (2) @(negedge clk);
         key = tbl[i].key;
         p = cyc;
         expect_ev(p + 4, tbl[i].kind, tbl[i].mc, tbl[i].lc);
         repeat (6) @(negedge clk);
         check($sformatf("vec%0d_busy", i), busy, (tbl[i].kind == 0) ? 1 : 0);
         check($sformatf("vec%0d_match_count", i), match_count, tbl[i].mc);
         check($sformatf("vec%0d_last_color", i), last_color, tbl[i].lc);
         key = 4'b0;
         repeat (4) @(negedge clk);
         check_events($sformatf("vec%0d", i));
      end

      // full correct round
      do_reset();
      pulse_start(c);
      expect_ev(c + 1, 0, 0, 0);
      repeat (2) @(negedge clk);
      key = 4'b0010; p = cyc;
      expect_ev(p + 4, 0, 1, 1);
      repeat (6) @(negedge clk);
      key = 4'b0000;
      repeat (4) @(negedge clk);
      key = 4'b0100; p = cyc;
      expect_ev(p + 4, 1, 2, 2);
      repeat (6) @(negedge clk);
      check("round_match_count", match_count, 2);
      check("round_last_color", last_color, 2);
      check("round_busy", busy, 0);
      key = 4'b0;
      repeat (2) @(negedge clk);
      check_events("round");

      // timeout with no key
      do_reset();
      pulse_start(c);
      expect_ev(c + 1, 0, 0, 0);
      expect_ev(c + 3 + TIMEOUT, 2, 0, 0);
      repeat (2 + TIMEOUT) @(negedge clk);
      check("timeout_busy_during_fail", busy, 1);
      @(negedge clk);
      check("timeout_busy_after", busy, 0);
      check_events("timeout");

      // held key, start while busy, then asynchronous reset mid-round
      do_reset();
      pulse_start(c);
      expect_ev(c + 1, 0, 0, 0);
      repeat (2) @(negedge clk);
      key = 4'b0010; p = cyc;
      expect_ev(p + 4, 0, 1, 1);
      repeat (20) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (19) @(negedge clk);
      check("held_busy", busy, 1);
      check("held_match_count", match_count, 1);
      check("held_last_color", last_color, 1);
      check_events("held");
      #2 resetn = 1'b0;
      #1;
      check("rst_busy", busy, 0);
      check("rst_next", next, 0);
      check("rst_pass", round_pass, 0);
      check("rst_fail", round_fail, 0);
      check("rst_match_count", match_count, 0);
      check("rst_last_color", last_color, 0);
      @(negedge clk);
      key = 4'b0;
      resetn = 1'b1;
      repeat (3) @(negedge clk);
      check("post_rst_busy", busy, 0);
      check("post_rst_match_count", match_count, 0);
      check_events("post_rst");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
